// File: rtl/jt1943_pkg.sv
// jt1943_pkg: shared ROM-slot FSM encoding for the char, scroll and object ROM slots
package jt1943_pkg;
  localparam logic [1:0] IDLE = 2'd0, REQ = 2'd1, WAIT = 2'd2;
  typedef enum logic [1:0] {ST_IDLE = IDLE, ST_REQ = REQ, ST_WAIT = WAIT} romslot_state_e;
endpackage

// File: rtl/jt1943_romslot_cache.sv
// jt1943_romslot_cache: 2-entry tag/data store with lookup on addr_i, write at replace pointer on we_i
module jt1943_romslot_cache #(
  parameter int AW = 14
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [AW-1:0] addr_i,
  output logic          hit_o,
  output logic [15:0]   data_o,
  input  logic          we_i,
  input  logic [AW-1:0] wtag_i,
  input  logic [15:0]   wdata_i
);
  logic [1:0]    valid_q;
  logic [AW-1:0] tag_q [2];
  logic [15:0]   data_q [2];
  logic          ptr_q;
  logic [1:0]    m;
  assign m      = {valid_q[1] && tag_q[1] == addr_i, valid_q[0] && tag_q[0] == addr_i};
  assign hit_o  = |m;
  assign data_o = m[0] ? data_q[0] : data_q[1];
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
      ptr_q   <= 1'b0;
    end else if (we_i) begin
      valid_q[ptr_q] <= 1'b1;
      tag_q[ptr_q]   <= wtag_i;
      data_q[ptr_q]  <= wdata_i;
      ptr_q          <= ~ptr_q;
    end
  end
endmodule

// File: rtl/jt1943_char_romslot.sv
// jt1943_char_romslot: cached char ROM slot; client cs/addr/dout/data_ok, SDRAM req/addr/ack/data_rdy/din
module jt1943_char_romslot
  import jt1943_pkg::*;
#(
  parameter int             AW   = 14,
  parameter int             SDW  = 22,
  parameter logic [SDW-1:0] BASE = '0
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           cs,
  input  logic [AW-1:0]  addr,
  output logic [15:0]    dout,
  output logic           data_ok,
  output logic           sdram_req,
  output logic [SDW-1:0] sdram_addr,
  input  logic           sdram_ack,
  input  logic           data_rdy,
  input  logic [15:0]    sdram_din
);
  romslot_state_e st_q, st_d;
  logic [AW-1:0]  tag_q, tag_d, dtag_q, dtag_d, wtag;
  logic [15:0]    dout_q, dout_d, hit_data;
  logic           ok_q, ok_d, hit, we;
  logic [SDW-1:0] sda_q, sda_d, cur_sda;
  assign cur_sda    = BASE + SDW'(addr);
  assign sdram_req  = st_q == ST_REQ;
  assign sdram_addr = st_q == ST_REQ ? cur_sda : sda_q;
  assign dout       = dout_q;
  assign data_ok    = ok_q;
  jt1943_romslot_cache #(.AW(AW)) u_cache (
    .clk     (clk),
    .rst     (rst),
    .addr_i  (addr),
    .hit_o   (hit),
    .data_o  (hit_data),
    .we_i    (we),
    .wtag_i  (wtag),
    .wdata_i (sdram_din)
  );
  always_comb begin
    st_d   = st_q;
    tag_d  = tag_q;
    sda_d  = sda_q;
    dout_d = dout_q;
    dtag_d = dtag_q;
    ok_d   = ok_q && addr == dtag_q;
    we     = 1'b0;
    wtag   = tag_q;
    case (st_q)
      ST_IDLE:
        if (cs && hit) begin
          dout_d = hit_data;
          dtag_d = addr;
          ok_d   = 1'b1;
        end else if (cs) begin
          ok_d = 1'b0;
          st_d = ST_REQ;
        end
      ST_REQ:
        if (sdram_ack) begin
          tag_d = addr;
          sda_d = cur_sda;
          wtag  = addr;
          we    = data_rdy;
          st_d  = data_rdy ? ST_IDLE : ST_WAIT;
        end
      ST_WAIT:
        if (data_rdy) begin
          we   = 1'b1;
          st_d = ST_IDLE;
        end
      default: st_d = ST_IDLE;
    endcase
    if (we && wtag == addr) begin
      dout_d = sdram_din;
      dtag_d = addr;
      ok_d   = 1'b1;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      st_q   <= ST_IDLE;
      tag_q  <= '0;
      sda_q  <= '0;
      dout_q <= '0;
      dtag_q <= '0;
      ok_q   <= 1'b0;
    end else begin
      st_q   <= st_d;
      tag_q  <= tag_d;
      sda_q  <= sda_d;
      dout_q <= dout_d;
      dtag_q <= dtag_d;
      ok_q   <= ok_d;
    end
  end
endmodule

// File: tb/tb_jt1943_char_romslot.sv
// tb_jt1943_char_romslot: table-driven and hand-sequenced checks of the char ROM slot
module tb_jt1943_char_romslot;
  logic        clk = 1'b0;
  logic        rst, cs, sdram_ack, data_rdy, data_ok, sdram_req;
  logic [13:0] addr;
  logic [15:0] dout, sdram_din;
  logic [21:0] sdram_addr;
  int n_chk = 0, n_fail = 0;
  logic [15:0] sb [$];
  typedef struct {
    logic [13:0] a;
    logic [15:0] d;
    logic        hit;
    int          ack_dly;
    int          rdy_dly;
  } vec_t;
  vec_t vec [12];
  jt1943_char_romslot dut (
    .clk        (clk),
    .rst        (rst),
    .cs         (cs),
    .addr       (addr),
    .dout       (dout),
    .data_ok    (data_ok),
    .sdram_req  (sdram_req),
    .sdram_addr (sdram_addr),
    .sdram_ack  (sdram_ack),
    .data_rdy   (data_rdy),
    .sdram_din  (sdram_din)
  );
  always #5 clk = ~clk;
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  initial begin
    vec[0]  = '{14'h0123, 16'hBEEF, 1'b0, 2, 7};
    vec[1]  = '{14'h0200, 16'h1111, 1'b0, 1, 2};
    vec[2]  = '{14'h0123, 16'hBEEF, 1'b1, 0, 0};
    vec[3]  = '{14'h0001, 16'hA001, 1'b0, 2, 3};
    vec[4]  = '{14'h0002, 16'hA002, 1'b0, 1, 1};
    vec[5]  = '{14'h0003, 16'hA003, 1'b0, 3, 2};
    vec[6]  = '{14'h0003, 16'hA003, 1'b1, 0, 0};
    vec[7]  = '{14'h0002, 16'hA002, 1'b1, 0, 0};
    vec[8]  = '{14'h0001, 16'hA001, 1'b0, 0, 0};
    vec[9]  = '{14'h0003, 16'hA003, 1'b1, 0, 0};
    vec[10] = '{14'h0002, 16'hA0B2, 1'b0, 1, 1};
    vec[11] = '{14'h0001, 16'hA001, 1'b1, 0, 0};
    rst = 1'b1; cs = 1'b0; addr = '0; sdram_ack = 1'b0; data_rdy = 1'b0; sdram_din = '0;
    tick;
    tick;
    chk("rst_dout", 32'(dout), 32'h0);
    chk("rst_ok", 32'(data_ok), 32'h0);
    chk("rst_req", 32'(sdram_req), 32'h0);
    chk("rst_sdaddr", 32'(sdram_addr), 32'h0);
    rst = 1'b0;
    cs = 1'b1;
    for (int i = 0; i < 12; i++) begin
      addr = vec[i].a;
      sb.push_back(vec[i].d);
      tick;
      if (vec[i].hit) begin
        chk($sformatf("v%0d_hit_noreq", i), 32'(sdram_req), 32'h0);
        chk($sformatf("v%0d_hit_ok", i), 32'(data_ok), 32'h1);
      end else begin
        chk($sformatf("v%0d_req", i), 32'(sdram_req), 32'h1);
        chk($sformatf("v%0d_sdaddr", i), 32'(sdram_addr), 32'(vec[i].a));
        chk($sformatf("v%0d_miss_ok", i), 32'(data_ok), 32'h0);
        repeat (vec[i].ack_dly) tick;
        sdram_ack = 1'b1;
        if (vec[i].rdy_dly == 0) begin
          data_rdy = 1'b1;
          sdram_din = vec[i].d;
        end
        tick;
        sdram_ack = 1'b0;
        data_rdy = 1'b0;
        chk($sformatf("v%0d_req_drop", i), 32'(sdram_req), 32'h0);
        if (vec[i].rdy_dly != 0) begin
          repeat (vec[i].rdy_dly - 1) tick;
          data_rdy = 1'b1;
          sdram_din = vec[i].d;
          tick;
          data_rdy = 1'b0;
        end
        chk($sformatf("v%0d_fill_ok", i), 32'(data_ok), 32'h1);
      end
      if (sb.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL v%0d_sb: scoreboard empty", i);
      end else chk($sformatf("v%0d_dout", i), 32'(dout), 32'(sb.pop_front()));
    end
    addr = 14'h0300;
    tick;
    chk("areq_req", 32'(sdram_req), 32'h1);
    chk("areq_sdaddr0", 32'(sdram_addr), 32'h0300);
    addr = 14'h0456;
    tick;
    chk("areq_req_hold", 32'(sdram_req), 32'h1);
    chk("areq_sdaddr1", 32'(sdram_addr), 32'h0456);
    sdram_ack = 1'b1;
    tick;
    sdram_ack = 1'b0;
    chk("areq_sdaddr_ack", 32'(sdram_addr), 32'h0456);
    chk("areq_req_drop", 32'(sdram_req), 32'h0);
    data_rdy = 1'b1;
    sdram_din = 16'h4560;
    tick;
    data_rdy = 1'b0;
    chk("areq_ok", 32'(data_ok), 32'h1);
    chk("areq_dout", 32'(dout), 32'h4560);
    addr = 14'h0300;
    tick;
    chk("areq_old_miss", 32'(sdram_req), 32'h1);
    sdram_ack = 1'b1; data_rdy = 1'b1; sdram_din = 16'h3000;
    tick;
    sdram_ack = 1'b0; data_rdy = 1'b0;
    chk("areq_old_dout", 32'(dout), 32'h3000);
    addr = 14'h0500;
    tick;
    chk("await_req", 32'(sdram_req), 32'h1);
    sdram_ack = 1'b1;
    tick;
    sdram_ack = 1'b0;
    addr = 14'h0600;
    data_rdy = 1'b1; sdram_din = 16'h5000;
    tick;
    data_rdy = 1'b0;
    chk("await_ok", 32'(data_ok), 32'h0);
    chk("await_dout_hold", 32'(dout), 32'h3000);
    tick;
    chk("await_newreq", 32'(sdram_req), 32'h1);
    chk("await_newaddr", 32'(sdram_addr), 32'h0600);
    sdram_ack = 1'b1; data_rdy = 1'b1; sdram_din = 16'h6000;
    tick;
    sdram_ack = 1'b0; data_rdy = 1'b0;
    chk("await_new_ok", 32'(data_ok), 32'h1);
    chk("await_new_dout", 32'(dout), 32'h6000);
    addr = 14'h0500;
    tick;
    chk("await_old_hit", 32'(data_ok), 32'h1);
    chk("await_old_noreq", 32'(sdram_req), 32'h0);
    chk("await_old_dout", 32'(dout), 32'h5000);
    addr = 14'h0700;
    tick;
    sdram_ack = 1'b1;
    tick;
    sdram_ack = 1'b0;
    rst = 1'b1; cs = 1'b0;
    tick;
    rst = 1'b0;
    chk("wrst_ok", 32'(data_ok), 32'h0);
    chk("wrst_dout", 32'(dout), 32'h0);
    chk("wrst_req", 32'(sdram_req), 32'h0);
    chk("wrst_sdaddr", 32'(sdram_addr), 32'h0);
    data_rdy = 1'b1; sdram_din = 16'h7777;
    tick;
    data_rdy = 1'b0;
    chk("late_rdy_ok", 32'(data_ok), 32'h0);
    chk("late_rdy_dout", 32'(dout), 32'h0);
    sdram_ack = 1'b1;
    tick;
    sdram_ack = 1'b0;
    chk("idle_ack_noreq", 32'(sdram_req), 32'h0);
    cs = 1'b1;
    addr = 14'h0500;
    tick;
    chk("empty_miss_req", 32'(sdram_req), 32'h1);
    chk("empty_miss_ok", 32'(data_ok), 32'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/jt1943_char_romslot.md
JT1943_CHAR_ROMSLOT -- requirements
Module: jt1943_char_romslot

Interface
REQ-001 SHALL have parameter AW, default 14, client address width in 16-bit words.
REQ-002 SHALL have parameter SDW, default 22, SDRAM word-address width.
REQ-003 SHALL have parameter BASE, default 22'h0, SDRAM word offset of the character ROM region.
REQ-004 SHALL have port clk  input  1  system clock (24 MHz); the only clock.
REQ-005 SHALL have port rst  input  1  reset, synchronous to clk and active-high.
REQ-006 SHALL have port cs  input  1  client enable; when low, no new SDRAM requests are started.
REQ-007 SHALL have port addr  input  AW  tile-row address from the character layer.
REQ-008 SHALL have port dout  output  16  ROM word for addr; drives the char layer's char_data.
REQ-009 SHALL have port data_ok  output  1  high when dout belongs to the current addr.
REQ-010 SHALL have port sdram_req  output  1  SDRAM read request level.
REQ-011 SHALL have port sdram_addr  output  SDW  SDRAM word address.
REQ-012 SHALL have port sdram_ack  input  1  one-cycle grant: the request was accepted.
REQ-013 SHALL have port data_rdy  input  1  one-cycle strobe: sdram_din is valid.
REQ-014 SHALL have port sdram_din  input  16  SDRAM read data.

Function
REQ-015 SHALL keep a 2-entry cache, each entry holding {valid, tag[AW-1:0], data[15:0]}, plus a 1-bit replace pointer.
REQ-016 Hit: cs=1, the address matches a valid tag, and the FSM is IDLE -> SHALL register the entry data to dout and set data_ok=1 on the next clk edge (1-cycle latency).
REQ-017 data_ok SHALL drop on the first edge after addr changes and the new address misses; dout SHALL hold its previous value until the fill completes.
REQ-018 FSM states SHALL be IDLE, REQ and WAIT.
REQ-019 IDLE -> REQ: on a miss with cs=1; sdram_req=1, sdram_addr=BASE+addr (zero-extended, modulo 2^SDW).
REQ-020 REQ: sdram_req SHALL stay high until sdram_ack; if addr changes before the ack, sdram_addr SHALL follow the new addr and the request SHALL continue.
REQ-021 REQ -> WAIT: on sdram_ack; sdram_req SHALL drop on the same edge; the request tag SHALL be latched.
REQ-022 WAIT -> IDLE: on data_rdy; sdram_din SHALL be written into the entry at the replace pointer with the latched tag and valid=1; the pointer SHALL toggle.
REQ-023 On that same edge, if the latched tag equals the current addr, dout=sdram_din and data_ok=1.
REQ-024 If addr changed during WAIT, the fill SHALL still complete under the old tag; the new addr SHALL be evaluated in IDLE on the next cycle.
REQ-025 sdram_ack and data_rdy high in the same REQ cycle SHALL be treated as ack followed by fill, going directly to IDLE.
REQ-026 sdram_ack outside REQ and data_rdy outside WAIT SHALL be ignored.
REQ-027 cs falling during REQ or WAIT SHALL NOT abort the transaction.
REQ-028 A hit SHALL NOT modify the replace pointer.
REQ-029 With a 24 MHz clk and SDRAM ack+data latency of at most 24 clk, miss-to-data_ok latency SHALL be at most 28 clk, inside the 8-pixel (32 clk) window of the char layer.

Reset
REQ-030 On rst=1 at a clk edge, the FSM SHALL go to IDLE; all valid bits and the pointer SHALL clear to 0; sdram_req=0, sdram_addr=0, dout=0 and data_ok=0.
REQ-031 rst asserted mid-transaction SHALL abandon the transaction; a data_rdy that arrives after reset SHALL be ignored.

Structure
REQ-032 The FSM state encoding (IDLE=0, REQ=1, WAIT=2) SHALL be localparams in the shared jt1943 package/include, for reuse by the scroll and object ROM slots.
REQ-033 The 2-entry tag/data store SHALL be a sub-module jt1943_romslot_cache (lookup, write, replace pointer); the FSM SHALL stay in the top module.

Verification
REQ-034 Cold miss: rst, then addr=14'h0123 with cs=1 -> sdram_req=1 and sdram_addr=22'h000123 with BASE=0; ack at +3, data_rdy with 16'hBEEF at +10 -> dout=16'hBEEF and data_ok=1 on the next edge.
REQ-035 Hit: addr 14'h0123 -> 14'h0200 (filled) -> back to 14'h0123 -> data_ok=1 one cycle later, no sdram_req.
REQ-036 Replacement: fill 14'h0001, 14'h0002 and 14'h0003 in turn -> 14'h0001 misses again; 14'h0002 and 14'h0003 still hit.
REQ-037 Address change in REQ: switch to 14'h0456 before the ack -> sdram_addr=22'h000456 at ack time; change in WAIT -> old tag cached, then a new request is issued.
REQ-038 Same-cycle ack+data_rdy -> FSM returns to IDLE, data_ok=1 next edge; rst during WAIT followed by a late data_rdy -> cache stays empty and data_ok=0.
